// File: rtl/toggle_decoder.sv
`default_nettype none
// ============================================================================
// Module   : toggle_decoder
// Purpose  : Recovers toggle-encoded events as single-cycle pulses, with
//            synchronisation, glitch filtering and a saturating event counter.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             q_in,
  input  logic             en,
  input  logic             clr,
  output logic             t_pulse,
  output logic             level,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             cnt_sat,
  output logic             glitch
);

  localparam int                    c_FILT_W    = (FILT_CYCLES < 2) ? 1 : $clog2(FILT_CYCLES);
  localparam logic [c_FILT_W-1:0]   c_FILT_LAST = c_FILT_W'(FILT_CYCLES - 1);
  localparam int                    c_INIT_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [c_INIT_W-1:0]   c_INIT_LAST = c_INIT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]      c_CNT_MAX   = '1;
  localparam bit                    c_FAST      = (FILT_CYCLES == 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_STABLE  = 2'd1,
    ST_CONFIRM = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  state_t                 state_q,    state_d;
  logic [c_INIT_W-1:0]    init_cnt_q, init_cnt_d;
  logic [c_FILT_W-1:0]    filt_cnt_q, filt_cnt_d;
  logic                   level_q,    level_d;
  logic                   t_pulse_q,  t_pulse_d;
  logic                   glitch_q,   glitch_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;
  logic                   sat_q,      sat_d;
  logic                   accept;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
    end
  end

  // INIT holds off until the synchroniser has flushed its reset zeros, so a
  // line already high at start-up is adopted as the baseline, not an event.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    filt_cnt_d = filt_cnt_q;
    level_d    = level_q;
    t_pulse_d  = 1'b0;
    glitch_d   = 1'b0;
    accept     = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == c_INIT_LAST) begin
          level_d = s;
          state_d = ST_STABLE;
        end else begin
          init_cnt_d = init_cnt_q + c_INIT_W'(1);
        end
      end

      ST_STABLE: begin
        if (!en) begin
          level_d = s;
        end else if (s != level_q) begin
          if (c_FAST) begin
            accept = 1'b1;
          end else begin
            filt_cnt_d = c_FILT_W'(1);
            state_d    = ST_CONFIRM;
          end
        end
      end

      ST_CONFIRM: begin
        if (!en) begin
          level_d = s;
          state_d = ST_STABLE;
        end else if (s == level_q) begin
          glitch_d = 1'b1;
          state_d  = ST_STABLE;
        end else if (filt_cnt_q == c_FILT_LAST) begin
          accept  = 1'b1;
          state_d = ST_STABLE;
        end else begin
          filt_cnt_d = filt_cnt_q + c_FILT_W'(1);
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (accept) begin
      level_d   = ~level_q;
      t_pulse_d = 1'b1;
    end
  end

  // clr wins over a same-cycle accept; the pulse and level still update.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (accept) begin
      if (cnt_q == c_CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      filt_cnt_q <= '0;
      level_q    <= 1'b0;
      t_pulse_q  <= 1'b0;
      glitch_q   <= 1'b0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      filt_cnt_q <= filt_cnt_d;
      level_q    <= level_d;
      t_pulse_q  <= t_pulse_d;
      glitch_q   <= glitch_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
    end
  end

  assign t_pulse    = t_pulse_q;
  assign level      = level_q;
  assign toggle_cnt = cnt_q;
  assign cnt_sat    = sat_q;
  assign glitch     = glitch_q;

endmodule
`default_nettype wire
